// File: rtl/fxd2flot_pkg.sv
// Shared helpers for the fixed-to-float pipeline: exponent bias, leading-one
// position width and float field offsets.
package fxd2flot_pkg;

  localparam int DEF_MAN = 23;
  localparam int DEF_EXP = 8;
  localparam int MAN_LO  = 0;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int pos_w(input int in_w);
    return ($clog2(in_w) > 1) ? $clog2(in_w) : 1;
  endfunction

  function automatic int sign_idx(input int man_w, input int exp_w);
    return man_w + exp_w;
  endfunction

  function automatic int exp_hi(input int man_w, input int exp_w);
    return man_w + exp_w - 1;
  endfunction

  function automatic int exp_lo(input int man_w);
    return man_w;
  endfunction

  function automatic int man_hi(input int man_w);
    return man_w - 1;
  endfunction

endpackage

// File: rtl/fxd2flot_lod.sv
// Combinational leading-one detector: highest set bit position plus an
// all-zero flag (position reads 0 when the vector is zero).
module fxd2flot_lod #(
  parameter int W  = 19,
  parameter int PW = 5
) (
  input  logic [W-1:0]  i_vec,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_pos = PW'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/fxd2flot_pipe.sv
// 3-stage fixed-point to float converter with valid/ready backpressure; all
// stages hold when the output is stalled. FXD2FLOT_RNE_EN selects RNE rounding.
module fxd2flot_pipe
  import fxd2flot_pkg::*;
#(
  parameter int IN_W   = 19,
  parameter int FRAC_W = 0,
  parameter int MAN    = DEF_MAN,
  parameter int EXP    = DEF_EXP,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP+MAN:0]   b,
  output logic               zro
);

  localparam int PW      = pos_w(IN_W);
  localparam int BIAS    = exp_bias(EXP);
  localparam int SGN_IDX = sign_idx(MAN, EXP);
  localparam int EXP_H   = exp_hi(MAN, EXP);
  localparam int EXP_L   = exp_lo(MAN);
  localparam int MAN_H   = man_hi(MAN);
  localparam logic [EXP-1:0] EXP_OFS = EXP'(BIAS - FRAC_W);

  if (!((IN_W - 1 - FRAC_W) < BIAS && FRAC_W >= 0 && FRAC_W <= BIAS - 1 &&
        IN_W >= 2 && MAN >= 1)) begin : g_bad_params
    $error("fxd2flot_pipe: parameters allow exponent overflow or underflow");
  end

  logic               w_adv;
  logic               w_neg;
  logic [IN_W-1:0]    w_mag;
  logic               r1_vld, r1_sgn, r1_zro;
  logic [IN_W-1:0]    r1_mag;
  logic [PW-1:0]      w_pos;
  logic               w_lod_zero;
  logic [PW-1:0]      w_shamt;
  logic [IN_W-2:0]    w_frac;
  logic               r2_vld, r2_sgn, r2_zro;
  logic [PW-1:0]      r2_p;
  logic [IN_W-2:0]    r2_frac;
  logic [MAN-1:0]     w_man;
  logic [EXP-1:0]     w_exp;
  logic [EXP+MAN:0]   w_res;
  logic               r3_vld, r3_zro;
  logic [EXP+MAN:0]   r3_b;

  assign w_adv    = out_ready | ~r3_vld;
  assign in_ready = w_adv;

  // Magnitude kept at IN_W bits: the most negative input maps to 1000..0.
  assign w_neg = (SIGNED != 0) && a[IN_W-1];
  assign w_mag = w_neg ? (~a + IN_W'(1)) : a;

  fxd2flot_lod #(.W(IN_W), .PW(PW)) u_lod (
    .i_vec  (r1_mag),
    .o_pos  (w_pos),
    .o_zero (w_lod_zero)
  );

  assign w_shamt = PW'(IN_W - 1) - w_pos;
  assign w_frac  = (IN_W-1)'(r1_mag << w_shamt);

`ifdef FXD2FLOT_RNE_EN
  logic [IN_W+MAN:0]  w_pad;
  logic               w_up;
  logic [MAN:0]       w_sum;

  // Mantissa LSB at IN_W+1, guard at IN_W, round at IN_W-1, sticky below.
  assign w_pad = {r2_frac, {(MAN+2){1'b0}}};
  assign w_up  = w_pad[IN_W] & (w_pad[IN_W-1] | (|w_pad[IN_W-2:0]) | w_pad[IN_W+1]);
  assign w_sum = {1'b0, w_pad[IN_W+MAN:IN_W+1]} + (MAN+1)'(w_up);
  assign w_man = w_sum[MAN-1:0];
  assign w_exp = EXP'(r2_p) + EXP_OFS + EXP'(w_sum[MAN]);
`else
  assign w_man = MAN'({r2_frac, {MAN{1'b0}}} >> (IN_W - 1));
  assign w_exp = EXP'(r2_p) + EXP_OFS;
`endif

  always_comb begin
    w_res = '0;
    if (!r2_zro) begin
      w_res[SGN_IDX]      = r2_sgn;
      w_res[EXP_H:EXP_L]  = w_exp;
      w_res[MAN_H:MAN_LO] = w_man;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_sgn  <= 1'b0;
      r1_zro  <= 1'b0;
      r1_mag  <= '0;
      r2_vld  <= 1'b0;
      r2_sgn  <= 1'b0;
      r2_zro  <= 1'b0;
      r2_p    <= '0;
      r2_frac <= '0;
      r3_vld  <= 1'b0;
      r3_zro  <= 1'b0;
      r3_b    <= '0;
    end else if (w_adv) begin
      r1_vld  <= in_valid;
      r1_sgn  <= w_neg;
      r1_zro  <= (a == '0);
      r1_mag  <= w_mag;
      r2_vld  <= r1_vld;
      r2_sgn  <= r1_sgn;
      r2_zro  <= r1_zro | w_lod_zero;
      r2_p    <= w_pos;
      r2_frac <= w_frac;
      r3_vld  <= r2_vld;
      r3_zro  <= r2_zro;
      r3_b    <= w_res;
    end
  end

  assign out_valid = r3_vld;
  assign b         = r3_b;
  assign zro       = r3_zro;

endmodule

// File: tb/tb_fxd2flot_pipe.sv
// Scoreboard bench for fxd2flot_pipe: four parameterisations share one clock;
// expected words are queued at accept and popped by per-instance monitors.
module tb_fxd2flot_pipe;

  typedef struct packed {
    logic [31:0] b;
    logic        z;
    logic        lat;
    logic [31:0] t;
  } exp_t;

`ifdef FXD2FLOT_RNE_EN
  localparam logic [31:0] W_E1 = 32'h4B800002;
  localparam logic [31:0] W_E2 = 32'h4C000000;
  localparam logic [31:0] W_E3 = 32'h4B800004;
`else
  localparam logic [31:0] W_E1 = 32'h4B800001;
  localparam logic [31:0] W_E2 = 32'h4BFFFFFF;
  localparam logic [31:0] W_E3 = 32'h4B800003;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy1 = 1'b1;
  logic [31:0] cyc = 32'd0;
  int          checks = 0;
  int          failures = 0;

  logic        iv0, ir0, ov0, or0, z0;
  logic [18:0] a0;
  logic [31:0] b0;
  logic        ivs, irs, ovs, zs;
  logic [18:0] as_;
  logic [31:0] bs;
  logic        ivw, irw, ovw, zw;
  logic [31:0] aw;
  logic [31:0] bw;
  logic        ivf, irf, ovf, zf;
  logic [18:0] af;
  logic [31:0] bf;

  exp_t q0[$], qs[$], qw[$], qf[$];
  logic        stall_prev = 1'b0;
  logic [31:0] b_prev = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  fxd2flot_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0),
    .out_valid(ov0), .out_ready(or0), .b(b0), .zro(z0));

  fxd2flot_pipe #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(ivs), .in_ready(irs), .a(as_),
    .out_valid(ovs), .out_ready(rdy1), .b(bs), .zro(zs));

  fxd2flot_pipe #(.IN_W(32)) dut_w (
    .clk(clk), .rst(rst), .in_valid(ivw), .in_ready(irw), .a(aw),
    .out_valid(ovw), .out_ready(rdy1), .b(bw), .zro(zw));

  fxd2flot_pipe #(.FRAC_W(4)) dut_f (
    .clk(clk), .rst(rst), .in_valid(ivf), .in_ready(irf), .a(af),
    .out_valid(ovf), .out_ready(rdy1), .b(bf), .zro(zf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic score(input string nm, input logic [31:0] bb, input logic zz, input exp_t e);
    chk({nm, " b"}, bb, e.b);
    chk({nm, " zro"}, 32'(zz), 32'(e.z));
    if (e.lat) chk({nm, " latency"}, cyc - e.t, 32'd3);
  endtask

  task automatic unexpected(input string nm, input logic [31:0] bb);
    checks++;
    failures++;
    $display("FAIL %s unexpected output actual=0x%08h required=none", nm, bb);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("stall out_valid held", 32'(ov0), 32'd1);
        chk("stall b held", b0, b_prev);
      end
      if (ov0 && !or0) chk("stall in_ready", 32'(ir0), 32'd0);
      if (ov0 && or0) begin
        if (q0.size() == 0) unexpected("main", b0);
        else score("main", b0, z0, q0.pop_front());
      end
      stall_prev = ov0 && !or0;
      b_prev     = b0;
      if (ovs) begin
        if (qs.size() == 0) unexpected("signed", bs);
        else score("signed", bs, zs, qs.pop_front());
      end
      if (ovw) begin
        if (qw.size() == 0) unexpected("wide", bw);
        else score("wide", bw, zw, qw.pop_front());
      end
      if (ovf) begin
        if (qf.size() == 0) unexpected("frac", bf);
        else score("frac", bf, zf, qf.pop_front());
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send0(input logic [18:0] av, input logic [31:0] eb, input logic ez, input logic lat);
    int n = 0;
    iv0 = 1'b1;
    a0  = av;
    @(negedge clk);
    while (!ir0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ir0) begin
      chk("main accept timeout", 32'(ir0), 32'd1);
    end else begin
      q0.push_back('{b: eb, z: ez, lat: lat, t: cyc});
    end
    @(posedge clk);
    #1 iv0 = 1'b0;
  endtask

  task automatic send_s(input logic [18:0] av, input logic [31:0] eb, input logic ez);
    ivs = 1'b1;
    as_ = av;
    @(negedge clk);
    chk("signed in_ready", 32'(irs), 32'd1);
    qs.push_back('{b: eb, z: ez, lat: 1'b1, t: cyc});
    @(posedge clk);
    #1 ivs = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] av, input logic [31:0] eb);
    ivw = 1'b1;
    aw  = av;
    @(negedge clk);
    chk("wide in_ready", 32'(irw), 32'd1);
    qw.push_back('{b: eb, z: 1'b0, lat: 1'b1, t: cyc});
    @(posedge clk);
    #1 ivw = 1'b0;
  endtask

  task automatic send_f(input logic [18:0] av, input logic [31:0] eb);
    ivf = 1'b1;
    af  = av;
    @(negedge clk);
    chk("frac in_ready", 32'(irf), 32'd1);
    qf.push_back('{b: eb, z: 1'b0, lat: 1'b1, t: cyc});
    @(posedge clk);
    #1 ivf = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + qs.size() + qw.size() + qf.size()) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  logic [18:0] st_a [5] = '{19'd2, 19'd4, 19'd5, 19'd6, 19'd7};
  logic [31:0] st_b [5] = '{32'h40000000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

  initial begin
    rst = 1'b1; iv0 = 1'b0; a0 = '0; or0 = 1'b1;
    ivs = 1'b0; as_ = '0; ivw = 1'b0; aw = '0; ivf = 1'b0; af = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(ov0), 32'd0);
    chk("reset b", b0, 32'd0);
    chk("reset zro", 32'(z0), 32'd0);
    chk("reset in_ready", 32'(ir0), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send0(19'd1024,    32'h44800000, 1'b0, 1'b1);
    send0(19'd65536,   32'h47800000, 1'b0, 1'b1);
    send0(19'd123456,  32'h47F12000, 1'b0, 1'b1);
    send0(19'd0,       32'h00000000, 1'b1, 1'b1);
    send0(19'd1,       32'h3F800000, 1'b0, 1'b1);
    send0(19'd3,       32'h40400000, 1'b0, 1'b1);
    send0(19'h7FFFF,   32'h48FFFFE0, 1'b0, 1'b1);
    drain();

    send_s(19'h7FFFF,  32'hBF800000, 1'b0);
    send_s(19'h40000,  32'hC8800000, 1'b0);
    send_s(19'd5,      32'h40A00000, 1'b0);
    send_s(19'h7FFFB,  32'hC0A00000, 1'b0);
    send_s(19'd0,      32'h00000000, 1'b1);
    send_w(32'h01000003, W_E1);
    send_w(32'h01FFFFFF, W_E2);
    send_w(32'h80000001, 32'h4F000000);
    send_w(32'h01000001, 32'h4B800000);
    send_w(32'h01000007, W_E3);
    send_f(19'd16,     32'h3F800000);
    send_f(19'd8,      32'h3F000000);
    send_f(19'h7FFFF,  32'h46FFFFE0);
    drain();

    fork
      begin
        for (int i = 0; i < 5; i++) send0(st_a[i], st_b[i], 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 or0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 or0 = 1'b1;
      end
    join
    drain();

    send0(19'd10, 32'h41200000, 1'b0, 1'b0);
    send0(19'd11, 32'h41300000, 1'b0, 1'b0);
    send0(19'd12, 32'h41400000, 1'b0, 1'b0);
    rst = 1'b1;
    q0.delete();
    #1;
    chk("mid reset out_valid", 32'(ov0), 32'd0);
    chk("mid reset b", b0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send0(19'd9, 32'h41100000, 1'b0, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;

    chk("main queue empty", 32'(q0.size()), 32'd0);
    chk("signed queue empty", 32'(qs.size()), 32'd0);
    chk("wide queue empty", 32'(qw.size()), 32'd0);
    chk("frac queue empty", 32'(qf.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
